// File: rtl/stream_merger_pkg.sv
// rtl/stream_merger_pkg.sv - shared stream burst-mode constants
package stream_merger_pkg;

    // Burst-mode selector values shared with the stream brancher
    localparam string STREAM_BURST_YES = "yes";
    localparam string STREAM_BURST_NO  = "no";

endpackage

// File: rtl/stream_merger_rr_arbiter2.sv
// rtl/stream_merger_rr_arbiter2.sv - two-request round-robin arbiter
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    // 1 = port 1 won the last transfer, so port 0 wins the next tie
    logic last_grant;

    // Single requester always wins; a tie goes to the port that did not win last
    always_comb begin
        gnt0 = req0 & (~req1 | last_grant);
        gnt1 = req1 & (~req0 | ~last_grant);
    end

    // Remember the winner only when a transfer actually happened
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= gnt1;
        end
    end

endmodule

// File: rtl/stream_merger.sv
// rtl/stream_merger.sv - two-input round-robin stream merger with one-word output slot
module stream_merger
    import stream_merger_pkg::*;
#(
    parameter int    WIDTH0 = 4,
    parameter int    WIDTH1 = 4,
    parameter string BURST  = STREAM_BURST_YES
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iValid_AM0,
    output logic                     oReady_AM0,
    input  logic [WIDTH0-1:0]        iData_AM0,
    input  logic                     iValid_AM1,
    output logic                     oReady_AM1,
    input  logic [WIDTH1-1:0]        iData_AM1,
    output logic                     oValid_BM,
    input  logic                     iReady_BM,
    output logic                     oSelect_BM,
    output logic [WIDTH1+WIDTH0-1:0] oData_BM
);

    // Burst mode lets the slot reload on the same edge it drains
    localparam bit BURST_MODE = (BURST == STREAM_BURST_YES);

    logic can_accept;
    logic gnt0;
    logic gnt1;
    logic accept;

    rr_arbiter2 u_arb (
        .clk     (iCLK),
        .rst_n   (iRST),
        .req0    (iValid_AM0),
        .req1    (iValid_AM1),
        .advance (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    // Slot availability and ready gating; ready is held low throughout reset
    always_comb begin
        if (BURST_MODE) begin
            can_accept = ~oValid_BM | iReady_BM;
        end else begin
            can_accept = ~oValid_BM;
        end
        oReady_AM0 = iRST & can_accept & gnt0;
        oReady_AM1 = iRST & can_accept & gnt1;
        accept     = (iValid_AM0 & oReady_AM0) | (iValid_AM1 & oReady_AM1);
    end

    // Output slot: load the granted word, otherwise empty on drain and hold data/select
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oValid_BM  <= 1'b0;
            oSelect_BM <= 1'b0;
            oData_BM   <= '0;
        end else if (accept) begin
            oValid_BM  <= 1'b1;
            oSelect_BM <= gnt1;
            oData_BM   <= gnt1 ? {iData_AM1, {WIDTH0{1'b0}}}
                               : {{WIDTH1{1'b0}}, iData_AM0};
        end else if (iReady_BM) begin
            oValid_BM  <= 1'b0;
        end
    end

endmodule
